// File: rtl/issue_arb.sv
// Round-robin issue arbiter with a one-entry output slot toward a functional unit.
// Optional per-requester grant and stall counters are enabled with ISSUE_ARB_PERF_EN.

package issue_arb_pkg;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [6:0]           opcode;
    logic [5:0]           pdst;
    logic [5:0]           psrc1;
    logic [5:0]           psrc2;
    logic [31:0]          imm;
  } rs_entry_t;
endpackage

module issue_arb
  import issue_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   recover_i,
  input  logic [ROB_DEPTH-1:0]   live_tag_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  rs_entry_t [N_REQ-1:0]  req_entry_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   fu_valid_o,
  output rs_entry_t              fu_entry_o,
  output logic [IDX_W-1:0]       fu_src_o,
`ifdef ISSUE_ARB_PERF_EN
  output logic [N_REQ-1:0][31:0] perf_grant_o,
  output logic [31:0]            perf_stall_o,
`endif
  input  logic                   fu_ready_i
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q, state_d;
  rs_entry_t        entry_q, entry_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic             full;
  logic             drain;
  logic             can_load;
  logic             found;
  logic             grant_en;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_vec;

  assign full     = (state_q == S_FULL);
  assign drain    = full && fu_ready_i;
  assign can_load = !full || drain;

  // Two-pass circular search: indices at/above rr_q first, then the wrapped part.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[i] && (IDX_W'(i) >= rr_q)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign grant_en = found && can_load && !flush_i && !recover_i;

  always_comb begin
    grant_vec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_vec[i] = grant_en && (IDX_W'(i) == grant_idx);
    end
  end

  // Reset only gates the visible grant; state flops are already held by the async reset.
  assign req_ready_o = grant_vec & {N_REQ{!rst}};

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      entry_d = '0;
      rr_d    = '0;
    end else if (recover_i) begin
      if (full && (!live_tag_i[entry_q.rob_tag] || fu_ready_i)) begin
        state_d = S_EMPTY;
        entry_d = '0;
      end
    end else if (grant_en) begin
      state_d = S_FULL;
      entry_d = req_entry_i[grant_idx];
      src_d   = grant_idx;
      rr_d    = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (drain) begin
      state_d = S_EMPTY;
      entry_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      entry_q <= '0;
      src_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign fu_valid_o = full;
  assign fu_entry_o = entry_q;
  assign fu_src_o   = src_q;

`ifdef ISSUE_ARB_PERF_EN
  logic [N_REQ-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [31:0]            perf_stall_q, perf_stall_d;

  always_comb begin
    perf_grant_d = perf_grant_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_vec[i]) begin
        perf_grant_d[i] = perf_grant_q[i] + 32'd1;
      end
    end
    perf_stall_d = (full && !fu_ready_i) ? perf_stall_q + 32'd1 : perf_stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_arb.sv
// Directed self-checking bench for issue_arb with N_REQ=3.
module tb_issue_arb;
  import issue_arb_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 flush_i;
  logic                 recover_i;
  logic [ROB_DEPTH-1:0] live_tag_i;
  logic [2:0]           req_valid_i;
  rs_entry_t [2:0]      req_entry_i;
  logic [2:0]           req_ready_o;
  logic                 fu_valid_o;
  rs_entry_t            fu_entry_o;
  logic [1:0]           fu_src_o;
  logic                 fu_ready_i;
`ifdef ISSUE_ARB_PERF_EN
  logic [2:0][31:0]     perf_grant_o;
  logic [31:0]          perf_stall_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  issue_arb #(.N_REQ(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .recover_i   (recover_i),
    .live_tag_i  (live_tag_i),
    .req_valid_i (req_valid_i),
    .req_entry_i (req_entry_i),
    .req_ready_o (req_ready_o),
    .fu_valid_o  (fu_valid_o),
    .fu_entry_o  (fu_entry_o),
    .fu_src_o    (fu_src_o),
`ifdef ISSUE_ARB_PERF_EN
    .perf_grant_o(perf_grant_o),
    .perf_stall_o(perf_stall_o),
`endif
    .fu_ready_i  (fu_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rs_entry_t mk(input logic [3:0] tag, input logic [6:0] op);
    rs_entry_t e;
    e.rob_tag = tag;
    e.opcode  = op;
    e.pdst    = {2'b10, tag};
    e.psrc1   = {2'b01, tag};
    e.psrc2   = {2'b11, tag};
    e.imm     = 32'hC0DE_0000 | {25'd0, op};
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; recover_i = 1'b0; live_tag_i = '1;
    req_valid_i = 3'b111; fu_ready_i = 1'b1;
    req_entry_i[0] = mk(4'd1, 7'h10);
    req_entry_i[1] = mk(4'd2, 7'h21);
    req_entry_i[2] = mk(4'd3, 7'h32);
    #2;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL reset_ready got=%b exp=000", req_ready_o); else pass_cnt++;
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== '0) $display("FAIL reset_entry got=%h exp=0", fu_entry_o); else pass_cnt++;
    total_cnt++; if (fu_src_o !== 2'd0) $display("FAIL reset_src got=%0d exp=0", fu_src_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL reset_hold_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_vec [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] exp_idx [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    req_valid_i = 3'b111; fu_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total_cnt++; if (req_ready_o !== exp_vec[k]) $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready_o, exp_vec[k]); else pass_cnt++;
      step();
      total_cnt++; if (fu_valid_o !== 1'b1) $display("FAIL rr_valid[%0d] got=%b exp=1", k, fu_valid_o); else pass_cnt++;
      total_cnt++; if (fu_src_o !== exp_idx[k]) $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, fu_src_o, exp_idx[k]); else pass_cnt++;
      total_cnt++; if (fu_entry_o !== req_entry_i[exp_idx[k]]) $display("FAIL rr_entry[%0d] got=%h exp=%h", k, fu_entry_o, req_entry_i[exp_idx[k]]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    req_valid_i = 3'b010; fu_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL bp_grant[%0d] got=%b exp=000", k, req_ready_o); else pass_cnt++;
      step();
      total_cnt++; if (fu_src_o !== 2'd2) $display("FAIL bp_hold_src[%0d] got=%0d exp=2", k, fu_src_o); else pass_cnt++;
    end
    fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b010) $display("FAIL bp_release got=%b exp=010", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_src_o !== 2'd1) $display("FAIL bp_src got=%0d exp=1", fu_src_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== req_entry_i[1]) $display("FAIL bp_entry got=%h exp=%h", fu_entry_o, req_entry_i[1]); else pass_cnt++;
  endtask

  task automatic test_recover();
    req_valid_i = 3'b000; fu_ready_i = 1'b1;
    step();
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL drain_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== '0) $display("FAIL drain_entry got=%h exp=0", fu_entry_o); else pass_cnt++;
    req_entry_i[0] = mk(4'd5, 7'h55);
    req_valid_i = 3'b001;
    #1;
    total_cnt++; if (req_ready_o !== 3'b001) $display("FAIL rc_load got=%b exp=001", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_entry_o.rob_tag !== 4'd5) $display("FAIL rc_tag got=%0d exp=5", fu_entry_o.rob_tag); else pass_cnt++;
    // dead tag: entry dropped, no grant
    recover_i = 1'b1; live_tag_i = ~(16'd1 << 5); fu_ready_i = 1'b0;
    #1;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL rc_dead_grant got=%b exp=000", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL rc_dead_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== '0) $display("FAIL rc_dead_entry got=%h exp=0", fu_entry_o); else pass_cnt++;
    recover_i = 1'b0; live_tag_i = '1; fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b001) $display("FAIL rc_reload got=%b exp=001", req_ready_o); else pass_cnt++;
    step();
    // live tag with FU stalled: retained
    recover_i = 1'b1; fu_ready_i = 1'b0;
    #1;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL rc_live_grant got=%b exp=000", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_valid_o !== 1'b1) $display("FAIL rc_live_valid got=%b exp=1", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== req_entry_i[0]) $display("FAIL rc_live_entry got=%h exp=%h", fu_entry_o, req_entry_i[0]); else pass_cnt++;
    // live tag with FU ready: drains, still no grant
    fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL rc_drain_grant got=%b exp=000", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL rc_drain_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    recover_i = 1'b0;
  endtask

  task automatic test_flush();
    req_valid_i = 3'b010; fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b010) $display("FAIL fl_pre got=%b exp=010", req_ready_o); else pass_cnt++;
    step();
    flush_i = 1'b1; req_valid_i = 3'b111; fu_ready_i = 1'b0;
    #1;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL fl_grant got=%b exp=000", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL fl_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== '0) $display("FAIL fl_entry got=%h exp=0", fu_entry_o); else pass_cnt++;
    flush_i = 1'b0; fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b001) $display("FAIL fl_rr_reset got=%b exp=001", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_src_o !== 2'd0) $display("FAIL fl_src got=%0d exp=0", fu_src_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    req_valid_i = 3'b100; fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b100) $display("FAIL wr_grant2 got=%b exp=100", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_src_o !== 2'd2) $display("FAIL wr_src2 got=%0d exp=2", fu_src_o); else pass_cnt++;
    req_valid_i = 3'b101;
    #1;
    total_cnt++; if (req_ready_o !== 3'b001) $display("FAIL wr_grant0 got=%b exp=001", req_ready_o); else pass_cnt++;
    step();
    total_cnt++; if (fu_src_o !== 2'd0) $display("FAIL wr_src0 got=%0d exp=0", fu_src_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    req_valid_i = 3'b101; fu_ready_i = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++; if (fu_valid_o !== 1'b0) $display("FAIL ar_valid got=%b exp=0", fu_valid_o); else pass_cnt++;
    total_cnt++; if (fu_entry_o !== '0) $display("FAIL ar_entry got=%h exp=0", fu_entry_o); else pass_cnt++;
    total_cnt++; if (req_ready_o !== 3'b000) $display("FAIL ar_ready got=%b exp=000", req_ready_o); else pass_cnt++;
    step();
    rst = 1'b0; req_valid_i = 3'b111; fu_ready_i = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 3'b001) $display("FAIL ar_rr got=%b exp=001", req_ready_o); else pass_cnt++;
    step();
  endtask

`ifdef ISSUE_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid_i = 3'b010; fu_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) step();
    req_valid_i = 3'b000; fu_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) step();
    total_cnt++; if (perf_grant_o[1] !== 32'd10) $display("FAIL pf_grant1 got=%0d exp=10", perf_grant_o[1]); else pass_cnt++;
    total_cnt++; if (perf_grant_o[0] !== 32'd0) $display("FAIL pf_grant0 got=%0d exp=0", perf_grant_o[0]); else pass_cnt++;
    total_cnt++; if (perf_stall_o !== 32'd3) $display("FAIL pf_stall got=%0d exp=3", perf_stall_o); else pass_cnt++;
    flush_i = 1'b1; req_valid_i = 3'b010; fu_ready_i = 1'b1;
    step();
    flush_i = 1'b0; req_valid_i = 3'b000;
    total_cnt++; if (perf_grant_o[1] !== 32'd10) $display("FAIL pf_flush_grant got=%0d exp=10", perf_grant_o[1]); else pass_cnt++;
    total_cnt++; if (perf_stall_o !== 32'd3) $display("FAIL pf_flush_stall got=%0d exp=3", perf_stall_o); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_recover();
    test_flush();
    test_wrap();
    test_async_reset();
`ifdef ISSUE_ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/issue_arb.md
# issue_arb

Round-robin issue arbiter that shares one execution-unit port among `N_REQ` reservation stations. Each reservation station presents a stable `issue_valid`/`issue_entry` pair until granted. This block grants exactly one requester per cycle and registers the winning entry into a one-entry output slot toward the functional unit. It honours recovery by dropping a buffered entry whose ROB tag is no longer live. It sits between the RS instances and the ALU/LSU/BRU issue ports in the backend.

## Interface
- `N_REQ`, default 3, number of requesting reservation stations (1..8).
- `IDX_W`, derived: 1 if `N_REQ`<=2, else clog2(`N_REQ`). It is the requester index width.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush_i` in 1: full pipeline flush.
- `recover_i` in 1: branch-recovery squash.
- `live_tag_i` in `ROB_DEPTH`: ROB live-tag bitmap, valid when `recover_i`=1.
- `req_valid_i` in `N_REQ`: per-RS issue valid.
- `req_entry_i` in `N_REQ` x `rs_entry_t`: per-RS issue entry.
- `req_ready_o` out `N_REQ`: per-RS grant, one-hot or zero.
- `fu_valid_o` out 1: output slot holds an entry.
- `fu_entry_o` out `rs_entry_t`: buffered entry; all-zero when the slot is empty.
- `fu_src_o` out `IDX_W`: index of the RS that supplied the buffered entry.
- `fu_ready_i` in 1: the FU accepts the slot this cycle.

## Operation
- Slot FSM has two states.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on drain (`fu_valid_o && fu_ready_i`) with no grant in the same cycle.
  - FULL -> FULL on drain plus grant in the same cycle.
- `can_load` = slot EMPTY, or slot is draining this cycle.
- Grant rule: if `can_load`, `!flush_i` and `!recover_i`, pick the first `i` with `req_valid_i[i]`=1.
  - The search is circular and starts at `rr_q`.
  - Drive `req_ready_o[i]`=1 and load `req_entry_i[i]` and `i` into the slot.
  - Otherwise all `req_ready_o` are 0.
- `req_ready_o` is combinational from `req_valid_i`, `rr_q`, the slot state, `fu_ready_i`, `flush_i` and `recover_i`. It never asserts for a requester with valid=0.
- `rr_q` is `IDX_W` bits. After a grant to `i`, it becomes `i+1`, wrapping from `N_REQ-1` to 0 (non-power-of-two `N_REQ` must wrap correctly). Without a grant it is unchanged.
- Flush has the highest priority: slot -> EMPTY, entry zeroed, `rr_q` -> 0, no grant.
- Recover is next:
  - If the slot is FULL and `live_tag_i[fu_entry_o.rob_tag]`=0, slot -> EMPTY and the entry is zeroed.
  - If the slot is FULL and the tag is live, the slot is retained and may still drain this cycle if `fu_ready_i`=1.
  - No grant is issued; `rr_q` is unchanged.
- `fu_ready_i` is ignored while the slot is EMPTY.
- The entry is not modified while in the slot; operand wakeup is the RS's responsibility before issue.

## Timing
- Grant in cycle t -> `fu_valid_o`=1 with that entry in cycle t+1.
- Sustained throughput is 1 entry/cycle while `fu_ready_i`=1 and any request is valid.
- Backpressure:
  - Slot FULL with `fu_ready_i`=0 -> no grants.
  - The RS keeps its selection stable, so no entry is lost.
- Reset (async assert, sync release): `fu_valid_o`=0, `fu_entry_o`=0, `fu_src_o`=0, `rr_q`=0, slot EMPTY. `req_ready_o`=0 while `rst`=1.
- Reset asserted mid-cycle discards the slot immediately; a grant whose edge coincides with reset is lost.
- Recover and flush take effect at the clock edge of the cycle they are asserted and suppress grants combinationally in that cycle.

## Configuration
- `ISSUE_ARB_PERF_EN` defined adds two outputs:
  - `perf_grant_o` [`N_REQ`] x 32: per-requester grant counts.
  - `perf_stall_o` 32: cycles with `fu_valid_o`=1 and `fu_ready_i`=0.
  - Both counters wrap modulo 2^32, clear only on `rst`, and are unaffected by flush/recover.
- `ISSUE_ARB_PERF_EN` undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Test plan
- All three requesters valid continuously, `fu_ready_i`=1, from reset: grants go to 0,1,2,0,1,2. `fu_src_o` follows one cycle later. `fu_valid_o` stays 1 from cycle 1.
- Slot FULL, `fu_ready_i`=0 for 4 cycles, requester 1 valid: `req_ready_o`=000 for 4 cycles. Requester 1 is granted in the cycle `fu_ready_i` returns to 1, and its entry appears on the next cycle.
- Slot holds `rob_tag`=5, `recover_i`=1 with `live_tag_i[5]`=0: `fu_valid_o`=0 next cycle and no grant in the recover cycle. Repeat with `live_tag_i[5]`=1: the entry is retained.
- `flush_i`=1 with slot FULL and `rr_q`=2: `fu_valid_o`=0 next cycle. The next grant with all requesters valid goes to requester 0.
- `N_REQ`=3, only requester 2 valid, granted: `rr_q` wraps to 0. A subsequent grant with requesters 0 and 2 valid goes to 0.
- With `ISSUE_ARB_PERF_EN`: 10 grants to requester 1 and 3 stall cycles -> `perf_grant_o[1]`=10 and `perf_stall_o`=3. Asserting `flush_i` leaves both unchanged.
